// File: rtl/ddr3_test_stats_pkg.sv
// Shared types for the DDR3 traffic statistics block.
package ddr3_test_stats_pkg;

    // Run-control FSM encoding; the raw value is exported on the state port.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_CALIB = 2'd1,
        ST_RUN        = 2'd2,
        ST_HALT       = 2'd3
    } state_t;

endpackage

// File: rtl/ddr3_test_stats_sat_counter.sv
// Saturating up-counter with synchronous clear. The next value is exported
// so that a snapshot taken on the same edge can include this cycle's increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    // Next value: clear has priority, increment stops at all-ones.
    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count != '1)) begin
            count_next = count + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/ddr3_test_stats.sv
// DDR3 traffic test statistics: run-control FSM, saturating write/read/error/
// cycle counters, first-miscompare capture and a valid/ack snapshot port.
//
// Snapshot handshake: a snap_req edge with snap_valid=0 (and no ctrl_clear)
// loads snap_* and raises snap_valid; snap_* stay frozen while snap_valid=1;
// an edge with snap_ack=1 while snap_valid=1 drops snap_valid on that edge.
module ddr3_test_stats
    import ddr3_test_stats_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int ADDR_W    = 27,
    parameter int ERR_LIMIT = 0
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              calib_done,
    input  logic              wr_ack,
    input  logic              rd_ack,
    input  logic              rd_err,
    input  logic [ADDR_W-1:0] rd_err_addr,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic              ctrl_clear,
    input  logic              snap_req,
    input  logic              snap_ack,
    output logic              snap_valid,
    output logic [CNT_W-1:0]  snap_wr_cnt,
    output logic [CNT_W-1:0]  snap_rd_cnt,
    output logic [CNT_W-1:0]  snap_err_cnt,
    output logic [CNT_W-1:0]  snap_cycles,
    output logic [ADDR_W-1:0] snap_first_err_addr,
    output logic [1:0]        state,
    output logic              err_sticky
);

    localparam logic [CNT_W-1:0] ERR_LIMIT_C = CNT_W'(ERR_LIMIT);

    state_t             state_q, state_d;
    logic               count_en, wr_inc, rd_inc, err_inc, err_hit, snap_take;
    logic [CNT_W-1:0]   wr_cnt, wr_next, rd_cnt, rd_next;
    logic [CNT_W-1:0]   err_cnt, err_next, cyc_cnt, cyc_next;
    logic [ADDR_W-1:0]  first_err_addr_q, first_err_addr_d;
    logic               err_sticky_q, err_sticky_d;

    // Events count for every cycle spent in RUN, including the exit cycle.
    assign count_en  = (state_q == ST_RUN) && !ctrl_clear;
    assign wr_inc    = count_en && wr_ack;
    assign rd_inc    = count_en && rd_ack;
    assign err_inc   = rd_inc && rd_err;
    assign err_hit   = (ERR_LIMIT != 0) && (err_next >= ERR_LIMIT_C);
    assign snap_take = snap_req && !snap_valid && !ctrl_clear;

    sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(ctrl_clear),
        .inc(wr_inc), .count(wr_cnt), .count_next(wr_next));

    sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(ctrl_clear),
        .inc(rd_inc), .count(rd_cnt), .count_next(rd_next));

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(ctrl_clear),
        .inc(err_inc), .count(err_cnt), .count_next(err_next));

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(ctrl_clear),
        .inc(count_en), .count(cyc_cnt), .count_next(cyc_next));

    // First-miscompare capture: only the first counted error since clear.
    always_comb begin
        first_err_addr_d = first_err_addr_q;
        err_sticky_d     = err_sticky_q;
        if (ctrl_clear) begin
            first_err_addr_d = '0;
            err_sticky_d     = 1'b0;
        end else if (err_inc && !err_sticky_q) begin
            first_err_addr_d = rd_err_addr;
            err_sticky_d     = 1'b1;
        end
    end

    // Next-state logic; clear beats everything, stop beats start.
    always_comb begin
        state_d = state_q;
        if (ctrl_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:       if (ctrl_start && !ctrl_stop) state_d = ST_WAIT_CALIB;
                // A stop while waiting for calibration aborts the run.
                ST_WAIT_CALIB: if (ctrl_stop)                state_d = ST_HALT;
                               else if (calib_done)          state_d = ST_RUN;
                ST_RUN:        if (ctrl_stop || err_hit)     state_d = ST_HALT;
                               else if (!calib_done)         state_d = ST_WAIT_CALIB;
                ST_HALT:       if (ctrl_start && !ctrl_stop) state_d = ST_WAIT_CALIB;
                default:                                     state_d = ST_IDLE;
            endcase
        end
    end

    // State and first-error registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q          <= ST_IDLE;
            first_err_addr_q <= '0;
            err_sticky_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            first_err_addr_q <= first_err_addr_d;
            err_sticky_q     <= err_sticky_d;
        end
    end

    // Snapshot registers: load post-edge live values, hold until acknowledged.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            snap_valid          <= 1'b0;
            snap_wr_cnt         <= '0;
            snap_rd_cnt         <= '0;
            snap_err_cnt        <= '0;
            snap_cycles         <= '0;
            snap_first_err_addr <= '0;
        end else if (snap_valid) begin
            if (snap_ack) snap_valid <= 1'b0;
        end else if (snap_take) begin
            snap_valid          <= 1'b1;
            snap_wr_cnt         <= wr_next;
            snap_rd_cnt         <= rd_next;
            snap_err_cnt        <= err_next;
            snap_cycles         <= cyc_next;
            snap_first_err_addr <= first_err_addr_d;
        end
    end

    assign state      = state_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_ddr3_test_stats.sv
// Bench for ddr3_test_stats with a 4-bit counter width and an error limit of 2.
module tb_ddr3_test_stats;

  localparam int CNT_W     = 4;
  localparam int ADDR_W    = 27;
  localparam int ERR_LIMIT = 2;
  localparam int SAT       = (1 << CNT_W) - 1;
  localparam int SNAP_W    = 4 * CNT_W + ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              calib_done, wr_ack, rd_ack, rd_err;
  logic [ADDR_W-1:0] rd_err_addr;
  logic              ctrl_start, ctrl_stop, ctrl_clear, snap_req, snap_ack;
  logic              snap_valid;
  logic [CNT_W-1:0]  snap_wr_cnt, snap_rd_cnt, snap_err_cnt, snap_cycles;
  logic [ADDR_W-1:0] snap_first_err_addr;
  logic [1:0]        state;
  logic              err_sticky;

  logic [SNAP_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         n_wr;
    int         n_rd;
    bit         do_stop;
    logic [1:0] exp_state;
    int         exp_wr;
    int         exp_rd;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[7];

  ddr3_test_stats #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .ERR_LIMIT(ERR_LIMIT)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .calib_done(calib_done),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .rd_err(rd_err), .rd_err_addr(rd_err_addr),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .ctrl_clear(ctrl_clear),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(snap_valid),
    .snap_wr_cnt(snap_wr_cnt), .snap_rd_cnt(snap_rd_cnt), .snap_err_cnt(snap_err_cnt),
    .snap_cycles(snap_cycles), .snap_first_err_addr(snap_first_err_addr),
    .state(state), .err_sticky(err_sticky));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_clear();
    ctrl_clear = 1'b1;
    step();
    ctrl_clear = 1'b0;
  endtask

  // Assumes calib_done=1: start edge -> WAIT_CALIB, next edge -> RUN.
  task automatic go_run();
    ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0;
    step();
  endtask

  task automatic push_exp(input int wr, input int rd, input int err, input int cyc,
                          input logic [ADDR_W-1:0] addr);
    exp_q.push_back({CNT_W'(wr), CNT_W'(rd), CNT_W'(err), CNT_W'(cyc), addr});
  endtask

  // scoreboard: wait (bounded) for snap_valid, pop and compare
  task automatic check_snap(input string tag);
    logic [CNT_W-1:0]  e_wr, e_rd, e_err, e_cyc;
    logic [ADDR_W-1:0] e_addr;
    int t = 0;
    while (!snap_valid && t < 10) begin
      step();
      t++;
    end
    chk({tag, "_snap_valid"}, snap_valid, 1);
    chk({tag, "_exp_q_nonempty"}, (exp_q.size() != 0), 1);
    if (snap_valid && exp_q.size() != 0) begin
      {e_wr, e_rd, e_err, e_cyc, e_addr} = exp_q.pop_front();
      chk({tag, "_wr"}, snap_wr_cnt, e_wr);
      chk({tag, "_rd"}, snap_rd_cnt, e_rd);
      chk({tag, "_err"}, snap_err_cnt, e_err);
      chk({tag, "_cyc"}, snap_cycles, e_cyc);
      chk({tag, "_addr"}, snap_first_err_addr, e_addr);
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic take_snap(input string tag, input int wr, input int rd, input int err,
                           input int cyc, input logic [ADDR_W-1:0] addr);
    snap_req = 1'b1;
    push_exp(wr, rd, err, cyc, addr);
    step();
    snap_req = 1'b0;
    check_snap(tag);
  endtask

  task automatic ack_snap(input string tag);
    snap_ack = 1'b1;
    step();
    snap_ack = 1'b0;
    chk({tag, "_valid_after_ack"}, snap_valid, 0);
  endtask

  initial begin
    int n;
    // vector table: hand-derived expectations (counters saturate at 15)
    vecs[0] = '{10, 7,  1'b1, 2'd3, 10, 7,  11};
    vecs[1] = '{20, 0,  1'b0, 2'd2, 15, 0,  15};
    vecs[2] = '{0,  3,  1'b1, 2'd3, 0,  3,  4};
    vecs[3] = '{5,  5,  1'b0, 2'd2, 5,  5,  6};
    vecs[4] = '{15, 16, 1'b1, 2'd3, 15, 15, 15};
    for (int i = 5; i < 7; i++) begin
      vecs[i].n_wr      = $urandom_range(0, 20);
      vecs[i].n_rd      = $urandom_range(0, 20);
      vecs[i].do_stop   = 1'($urandom_range(0, 1));
      vecs[i].exp_state = vecs[i].do_stop ? 2'd3 : 2'd2;
      vecs[i].exp_wr    = (vecs[i].n_wr > SAT) ? SAT : vecs[i].n_wr;
      vecs[i].exp_rd    = (vecs[i].n_rd > SAT) ? SAT : vecs[i].n_rd;
      n = (vecs[i].n_wr > vecs[i].n_rd) ? vecs[i].n_wr : vecs[i].n_rd;
      vecs[i].exp_cyc   = (n + 1 > SAT) ? SAT : n + 1;
    end

    rst_n = 1'b0;
    calib_done = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0; rd_err = 1'b0;
    rd_err_addr = '0;
    ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_clear = 1'b0;
    snap_req = 1'b0; snap_ack = 1'b0;
    step();
    step();

    // reset state
    chk("rst_state", state, 0);
    chk("rst_snap_valid", snap_valid, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_snap_wr", snap_wr_cnt, 0);
    chk("rst_snap_cyc", snap_cycles, 0);

    // first start after release is honoured immediately
    rst_n = 1'b1;
    ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0;
    chk("start_first_edge", state, 1);
    step();
    chk("wait_calib_hold", state, 1);
    calib_done = 1'b1;
    step();
    chk("calib_to_run", state, 2);
    calib_done = 1'b0;
    step();
    chk("calib_loss", state, 1);
    calib_done = 1'b1;
    step();
    chk("calib_back", state, 2);
    ctrl_start = 1'b1; ctrl_stop = 1'b1;
    step();
    chk("stop_wins_run", state, 3);
    step();
    chk("stop_wins_halt", state, 3);
    ctrl_stop = 1'b0;
    step();
    ctrl_start = 1'b0;
    chk("halt_restart", state, 1);

    // table-driven traffic runs
    for (int v = 0; v < 7; v++) begin
      pulse_clear();
      calib_done = 1'b1;
      go_run();
      chk($sformatf("v%0d_run", v), state, 2);
      n = (vecs[v].n_wr > vecs[v].n_rd) ? vecs[v].n_wr : vecs[v].n_rd;
      for (int i = 0; i < n; i++) begin
        wr_ack = (i < vecs[v].n_wr);
        rd_ack = (i < vecs[v].n_rd);
        step();
      end
      wr_ack = 1'b0; rd_ack = 1'b0;
      if (vecs[v].do_stop) begin
        ctrl_stop = 1'b1;
        step();
        ctrl_stop = 1'b0;
      end
      take_snap($sformatf("v%0d", v), vecs[v].exp_wr, vecs[v].exp_rd, 0,
                vecs[v].exp_cyc, '0);
      chk($sformatf("v%0d_state", v), state, vecs[v].exp_state);
      ack_snap($sformatf("v%0d", v));
    end

    // error limit: ignored err without ack, then errors at 0x100 and 0x200
    pulse_clear();
    go_run();
    rd_ack = 1'b0; rd_err = 1'b1; rd_err_addr = 27'h300;
    step();
    chk("err_unqualified", err_sticky, 0);
    rd_ack = 1'b1; rd_err_addr = 27'h100;
    step();
    chk("err1_state", state, 2);
    chk("err1_sticky", err_sticky, 1);
    rd_err_addr = 27'h200;
    step();
    rd_ack = 1'b0; rd_err = 1'b0;
    chk("err2_halt", state, 3);
    chk("err2_sticky", err_sticky, 1);
    take_snap("errlim", 0, 2, 2, 3, 27'h100);
    ack_snap("errlim");

    // clear together with wr_ack, snap_req and start
    pulse_clear();
    go_run();
    wr_ack = 1'b1;
    repeat (3) step();
    ctrl_clear = 1'b1; snap_req = 1'b1; ctrl_start = 1'b1;
    step();
    ctrl_clear = 1'b0; snap_req = 1'b0; ctrl_start = 1'b0; wr_ack = 1'b0;
    chk("clr_state", state, 0);
    chk("clr_snap_valid", snap_valid, 0);
    chk("clr_sticky", err_sticky, 0);
    step();
    chk("clr_snap_valid_later", snap_valid, 0);
    take_snap("clr", 0, 0, 0, 0, '0);
    ack_snap("clr");

    // snapshot held while snap_req repeats; same-edge increment captured
    pulse_clear();
    go_run();
    wr_ack = 1'b1;
    step();
    step();
    snap_req = 1'b1;
    push_exp(3, 0, 0, 3, '0);
    step();
    check_snap("hold");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d_valid", i), snap_valid, 1);
      chk($sformatf("hold%0d_wr", i), snap_wr_cnt, 3);
      chk($sformatf("hold%0d_cyc", i), snap_cycles, 3);
    end
    ack_snap("hold");
    snap_req = 1'b0; wr_ack = 1'b0;
    step();
    chk("hold_no_retake", snap_valid, 0);
    take_snap("after_hold", 7, 0, 0, 9, '0);

    // async reset mid-RUN with a pending snapshot and sticky error
    rd_ack = 1'b1; rd_err = 1'b1; rd_err_addr = 27'h55;
    step();
    rd_ack = 1'b0; rd_err = 1'b0;
    chk("pre_rst_state", state, 2);
    chk("pre_rst_sticky", err_sticky, 1);
    chk("pre_rst_valid", snap_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_snap_valid", snap_valid, 0);
    chk("arst_sticky", err_sticky, 0);
    chk("arst_snap_wr", snap_wr_cnt, 0);
    chk("arst_snap_cyc", snap_cycles, 0);
    chk("arst_snap_addr", snap_first_err_addr, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr3_test_stats.md
DDR3_TEST_STATS -- requirements
Module: ddr3_test_stats

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, meaning width of every event/cycle counter.
REQ-002 The block SHALL have parameter ADDR_W, default 27, meaning width of the DDR3 traffic address reported on a miscompare.
REQ-003 The block SHALL have parameter ERR_LIMIT, default 0, meaning the error count that forces HALT (0 = never halt on errors).
REQ-004 Clock and reset SHALL be single clock S_AXI_ACLK with reset S_AXI_ARESETN, asynchronous, active-low.
REQ-005 Ports (name direction width meaning):
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  async active-low reset
- calib_done  in  1  DDR3 calibration complete (level)
- wr_ack  in  1  one write transfer retired (pulse)
- rd_ack  in  1  one read transfer retired (pulse)
- rd_err  in  1  miscompare on this rd_ack, ignored unless rd_ack=1
- rd_err_addr  in  ADDR_W  address of the read qualified by rd_ack
- ctrl_start / ctrl_stop / ctrl_clear  in  1 each  register-side command pulses
- snap_req  in  1  request counter snapshot (pulse)
- snap_ack  in  1  register side consumed snapshot
- snap_valid  out  1  snapshot outputs stable
- snap_wr_cnt / snap_rd_cnt / snap_err_cnt / snap_cycles  out  CNT_W each  snapshot values
- snap_first_err_addr  out  ADDR_W  address of first miscompare since clear
- state  out  2  FSM state encoding
- err_sticky  out  1  at least one miscompare since clear

Function
REQ-006 The FSM SHALL have states IDLE=0, WAIT_CALIB=1, RUN=2, HALT=3, exposed directly on state.
REQ-007 The FSM SHALL take these transitions: IDLE->WAIT_CALIB on ctrl_start; WAIT_CALIB->RUN when calib_done=1; RUN->HALT on ctrl_stop, or when err_count reaches ERR_LIMIT (ERR_LIMIT>0); HALT->WAIT_CALIB on ctrl_start.
REQ-008 ctrl_clear SHALL force IDLE, zero all live counters and first_err_addr, and clear err_sticky, overriding any simultaneous start/stop/event.
REQ-009 ctrl_stop SHALL win over a simultaneous ctrl_start in any state.
REQ-010 wr_ack, rd_ack and rd_err SHALL be counted only in RUN, including the cycle in which stop or the error-limit condition causes the RUN->HALT transition.
REQ-011 The cycle counter SHALL increment on every clock spent in RUN.
REQ-012 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-013 err_sticky SHALL be set on the first counted rd_err, and rd_err_addr SHALL be latched into first_err_addr at that time only.
REQ-014 If calib_done deasserts in RUN, the FSM SHALL go to WAIT_CALIB, counters held.
REQ-015 When snap_req=1 and snap_valid=0, all live values (including those updated this cycle) SHALL be copied to the snap_* outputs on that edge, with snap_valid=1 from the next cycle.
REQ-016 snap_valid SHALL hold with snap_* stable until a cycle with snap_ack=1, and SHALL deassert on the following cycle.
REQ-017 snap_req SHALL be ignored while snap_valid=1 or in a ctrl_clear cycle.
REQ-018 snap_ack while snap_valid=0 SHALL have no effect.

Reset
REQ-019 Asserting reset SHALL immediately force state=IDLE, snap_valid=0, err_sticky=0, and every counter and snap_* output to 0, including mid-RUN or while a snapshot is pending.
REQ-020 After release, the first ctrl_start SHALL be honoured on the first rising edge.

Structure
REQ-021 Shared package ddr3_test_stats_pkg SHALL hold the state enum type and its 2-bit encodings.
REQ-022 One sub-module SHALL be used: sat_counter (CNT_W, inc, clr, saturating), instantiated four times.

Verification
REQ-023 Bench SHALL cover: reset, start with calib_done=1, 10 wr_ack and 7 rd_ack, stop, snap_req -> snap_wr_cnt=10, snap_rd_cnt=7, snap_err_cnt=0, state=3.
REQ-024 Bench SHALL cover: ERR_LIMIT=2, rd_err at addresses 0x100 then 0x200 -> HALT on the 2nd error, first_err_addr=0x100, err_sticky=1.
REQ-025 Bench SHALL cover: CNT_W=4, 20 wr_ack in RUN -> snap_wr_cnt=15.
REQ-026 Bench SHALL cover: ctrl_clear together with wr_ack and snap_req -> counters 0, state=0, snap_valid stays 0.
REQ-027 Bench SHALL cover: snap_req while snap_valid=1, then snap_ack -> snapshot unchanged until ack, and snap_valid=0 one cycle after ack.
REQ-028 Bench SHALL cover: S_AXI_ARESETN low mid-RUN with snap_valid=1 -> all outputs 0 asynchronously, without waiting for a clock edge.
